// File: rtl/output_req_arbiter.sv
// Round-robin arbiter: grants one vertex buffer bank at a time and streams that bank's
// node into the output SRAM, issuing one registered write per received beat.

`ifndef MAX_FV_num
`define MAX_FV_num 8
`endif
`ifndef Max_Node_id
`define Max_Node_id 16
`endif

package output_req_arbiter_pkg;
    localparam int NODE_W = $clog2(`Max_Node_id);

    typedef struct packed {
        logic              req;
        logic              Grant_valid;
        logic              sos;
        logic              eos;
        logic [15:0]       data;
        logic [NODE_W-1:0] Node_id;
    } Bank_Req2Req_Output_SRAM;
endpackage

module output_req_arbiter
    import output_req_arbiter_pkg::*;
#(
    parameter int NUM_BANK = 4,
    parameter int WPN      = `MAX_FV_num/2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  Bank_Req2Req_Output_SRAM [NUM_BANK-1:0]    bank_pkt,
    output logic [NUM_BANK-1:0]                       req_grant,
    output logic                                      sram_wen,
    output logic [NODE_W+$clog2(WPN)-1:0]             sram_addr,
    output logic [15:0]                               sram_wdata,
    output logic                                      wr_done,
    output logic [NODE_W-1:0]                         done_node_id,
    output logic                                      proto_err,
    output logic                                      busy
);
    localparam int SEL_W  = $clog2(NUM_BANK);
    localparam int BEAT_W = $clog2(WPN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WPN-1);
    localparam logic [SEL_W-1:0]  LAST_BANK = SEL_W'(NUM_BANK-1);

    typedef enum logic [1:0] {IDLE, GRANT, RECV} state_t;

    state_t                    r_state;
    logic [SEL_W-1:0]          r_rr_ptr;
    logic [SEL_W-1:0]          r_sel;
    logic [BEAT_W-1:0]         r_beat_cnt;
    logic [NODE_W-1:0]         r_node_id;
    logic [NUM_BANK-1:0]       r_req_grant;
    logic                      r_wen;
    logic [NODE_W+BEAT_W-1:0]  r_addr;
    logic [15:0]               r_wdata;
    logic                      r_wr_done;
    logic [NODE_W-1:0]         r_done_node_id;
    logic                      r_proto_err;
    logic                      r_busy;

    logic                      w_any;
    logic [SEL_W-1:0]          w_pick;
    logic                      w_gv;
    logic                      w_sos;
    logic                      w_eos;
    logic [15:0]               w_data;
    logic [NODE_W-1:0]         w_node;

    // Only the selected bank's fields ever reach the datapath.
    assign w_gv   = bank_pkt[r_sel].Grant_valid;
    assign w_sos  = bank_pkt[r_sel].sos;
    assign w_eos  = bank_pkt[r_sel].eos;
    assign w_data = bank_pkt[r_sel].data;
    assign w_node = bank_pkt[r_sel].Node_id;

    // Scan offsets from the highest down so the requester closest to rr_ptr wins.
    always_comb begin
        logic [SEL_W-1:0] idx;
        idx    = '0;
        w_any  = 1'b0;
        w_pick = r_rr_ptr;
        for (int k = NUM_BANK - 1; k >= 0; k--) begin
            idx = SEL_W'((int'(r_rr_ptr) + k) % NUM_BANK);
            if (bank_pkt[idx].req) begin
                w_any  = 1'b1;
                w_pick = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: every register, pulse outputs included, is cleared by the synchronous
        // reset so an aborted transfer cannot leak a write into the next cycle.
        if (!reset) begin
            r_state        <= IDLE;
            r_rr_ptr       <= '0;
            r_sel          <= '0;
            r_beat_cnt     <= '0;
            r_node_id      <= '0;
            r_req_grant    <= '0;
            r_wen          <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_wr_done      <= 1'b0;
            r_done_node_id <= '0;
            r_proto_err    <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_req_grant <= '0;
            r_wen       <= 1'b0;
            r_wr_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_sel       <= w_pick;
                        r_req_grant <= NUM_BANK'(1) << w_pick;
                        r_state     <= GRANT;
                        r_busy      <= 1'b1;
                    end
                end
                GRANT: begin
                    r_rr_ptr <= (r_sel == LAST_BANK) ? '0 : r_sel + 1'b1;
                    if (w_gv && w_sos) begin
                        r_node_id  <= w_node;
                        r_wen      <= 1'b1;
                        r_addr     <= {w_node, BEAT_W'(0)};
                        r_wdata    <= w_data;
                        r_beat_cnt <= BEAT_W'(1);
                        if (w_eos) begin
                            r_wr_done      <= 1'b1;
                            r_done_node_id <= w_node;
                            r_state        <= IDLE;
                            r_busy         <= 1'b0;
                        end else begin
                            r_state <= RECV;
                        end
                    end else begin
                        r_proto_err <= 1'b1;
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                    end
                end
                RECV: begin
                    // A missing eos on the last legal index is an overflow: nothing is written.
                    if (!w_gv || w_sos || (r_beat_cnt == LAST_BEAT && !w_eos)) begin
                        r_proto_err <= 1'b1;
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                    end else begin
                        r_wen      <= 1'b1;
                        r_addr     <= {r_node_id, r_beat_cnt};
                        r_wdata    <= w_data;
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (w_eos) begin
                            r_wr_done      <= 1'b1;
                            r_done_node_id <= r_node_id;
                            r_state        <= IDLE;
                            r_busy         <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign req_grant    = r_req_grant;
    assign sram_wen     = r_wen;
    assign sram_addr    = r_addr;
    assign sram_wdata   = r_wdata;
    assign wr_done      = r_wr_done;
    assign done_node_id = r_done_node_id;
    assign proto_err    = r_proto_err;
    assign busy         = r_busy;

endmodule

// File: doc/output_req_arbiter.md
OUTPUT_REQ_ARBITER -- requirements
Module: output_req_arbiter

Interface
REQ-001 Parameter NUM_BANK, default 4, number of vertex buffer banks served.
REQ-002 Parameter WPN, default `MAX_FV_num/2, number of 16-bit output words per node.
REQ-003 clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low; sampled only on posedge clk.
REQ-005 bank_pkt  input  NUM_BANK x Bank_Req2Req_Output_SRAM  per-bank req, Grant_valid, sos, eos, data[15:0], Node_id.
REQ-006 req_grant  output  NUM_BANK  one-hot grant pulse, one bit per bank.
REQ-007 sram_wen  output  1  output SRAM write enable, active high.
REQ-008 sram_addr  output  $clog2(`Max_Node_id)+$clog2(WPN)  write address = {Node_id, beat index}.
REQ-009 sram_wdata  output  16  write data; {FV[2k+1], FV[2k]} exactly as received.
REQ-010 wr_done  output  1  one-cycle pulse when a node's last word is written.
REQ-011 done_node_id  output  $clog2(`Max_Node_id)  Node_id of the completed node; valid with wr_done.
REQ-012 proto_err  output  1  sticky protocol-error flag.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, GRANT, RECV; all outputs are registered unless stated.
REQ-015 IDLE: if any bank_pkt[i].req high, select the first requester at or after rr_ptr (wrapping modulo NUM_BANK), latch sel, go to GRANT.
REQ-016 GRANT: req_grant[sel]=1 for exactly this one cycle, driven from state; all other req_grant bits stay 0.
REQ-017 GRANT: a beat with Grant_valid=1 and sos=1 from bank sel is expected in the same cycle; on receipt, latch Node_id, write beat 0, and set beat_cnt=1.
REQ-018 GRANT: if that beat also has eos=1, go to IDLE; otherwise go to RECV.
REQ-019 GRANT: if Grant_valid=0 or sos=0 on bank sel, set proto_err, perform no write, and go to IDLE.
REQ-020 RECV: each cycle requires Grant_valid=1 and sos=0 from bank sel; write the beat at address {latched Node_id, beat_cnt}, then increment beat_cnt.
REQ-021 RECV: on eos=1, write the beat and go to IDLE.
REQ-022 RECV: Grant_valid=0, sos=1, or beat_cnt==WPN-1 without eos sets proto_err and returns to IDLE; no write at the overflow index.
REQ-023 Write latency: sram_wen, sram_addr and sram_wdata are asserted the cycle after the beat is received; one write per beat, with no gaps and no back-pressure.
REQ-024 wr_done and done_node_id assert in the same cycle as the write of the eos beat.
REQ-025 rr_ptr updates to (sel+1) mod NUM_BANK when leaving GRANT, whether or not the transfer succeeded.
REQ-026 Requests from unselected banks are ignored while busy; they are arbitered again once the FSM returns to IDLE, with no loss.
REQ-027 Leaving RECV enters IDLE for one cycle; the earliest next grant is 2 cycles after the final beat.
REQ-028 Packet fields from non-selected banks never affect writes.

Reset
REQ-029 With reset=0 at posedge clk: state=IDLE, rr_ptr=0, beat_cnt=0, sel=0, req_grant=0, sram_wen=0, sram_addr=0, sram_wdata=0, wr_done=0, done_node_id=0, proto_err=0, busy=0.
REQ-030 Reset asserted mid-transfer aborts the transfer; no write is issued in the following cycle; proto_err is cleared only by reset.

Verification
REQ-031 Bank 1 req, Node_id=5, 4 beats 0x0201,0x0403,0x0605,0x0807 (last with eos) -> req_grant=4'b0010 for one cycle; writes to addr {5,0..3} on consecutive cycles; wr_done with done_node_id=5 on the 4th write.
REQ-032 Banks 0,2,3 req simultaneously after reset -> grant order 0,2,3; then bank 0 re-requests -> bank 0 is granted next.
REQ-033 Single-beat node (sos=eos=1, data 0x00AA, Node_id=9) -> one write at {9,0}, wr_done the same cycle, FSM returns to IDLE.
REQ-034 Grant_valid dropped at beat 2 -> proto_err=1, no further writes, busy=0 next cycle, proto_err stays high until reset.
REQ-035 WPN beats without eos -> proto_err=1, exactly WPN-1 writes.
REQ-036 reset=0 during RECV at beat 2 -> no write in the next cycle, all outputs at reset values, clean grant on next req.
